// File: rtl/regfile_arbiter_if.sv
// Requester and register-file signal bundle for regfile_arbiter.
// slave = arbiter side, master = requesters plus register file side.
interface regfile_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              rvalid_a;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              busy;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_ra;
  logic [ADDR_W-1:0] rf_rb;
  logic [ADDR_W-1:0] rf_rw;
  logic [DATA_W-1:0] rf_busw;
  logic [DATA_W-1:0] rf_busa;
  logic [DATA_W-1:0] rf_busb;

  modport slave (
    input  req_a, req_b, we_a, we_b,
    input  addr_a, addr_b, wdata_a, wdata_b,
    input  rf_busa, rf_busb,
    output gnt_a, gnt_b, rvalid_a, rvalid_b,
    output rdata_a, rdata_b, busy,
    output rf_write_enable, rf_ra, rf_rb, rf_rw, rf_busw
  );

  modport master (
    output req_a, req_b, we_a, we_b,
    output addr_a, addr_b, wdata_a, wdata_b,
    output rf_busa, rf_busb,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b,
    input  rdata_a, rdata_b, busy,
    input  rf_write_enable, rf_ra, rf_rb, rf_rw, rf_busw
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-port round-robin arbiter in front of the 16x4 register file.
// REGFILE_ARB_DUAL_READ_EN: grant two simultaneous reads together.
module regfile_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  regfile_arbiter_if.slave bus
);

`ifdef REGFILE_ARB_DUAL_READ_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   sa_q, sa_d;
  logic   sb_q, sb_d;
  logic   wr_q, wr_d;
  logic   gnt_a_q, gnt_a_d;
  logic   gnt_b_q, gnt_b_d;
  logic   rv_a_q, rv_a_d;
  logic   rv_b_q, rv_b_d;
  logic   busy_q, busy_d;
  logic   we_q, we_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic [DATA_W-1:0] busw_q, busw_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic [ADDR_W-1:0] rw_q, rw_d;

  logic dual, pick_a, pick_b;

  // last_q = 1 means B won last, so A wins contention
  assign dual   = DUAL & bus.req_a & bus.req_b
                & ~bus.we_a & ~bus.we_b;
  assign pick_a = ~dual & bus.req_a
                & (~bus.req_b | last_q);
  assign pick_b = ~dual & bus.req_b & ~pick_a;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    wr_d      = wr_q;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    rv_a_d    = 1'b0;
    rv_b_d    = 1'b0;
    we_d      = 1'b0;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rw_d      = rw_q;
    busw_d    = busw_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          dual: begin
            gnt_a_d = 1'b1;
            gnt_b_d = 1'b1;
            sa_d    = 1'b1;
            sb_d    = 1'b1;
            wr_d    = 1'b0;
            ra_d    = bus.addr_a;
            rb_d    = bus.addr_b;
            state_d = ISSUE;
          end
          pick_a: begin
            gnt_a_d = 1'b1;
            sa_d    = 1'b1;
            sb_d    = 1'b0;
            last_d  = 1'b0;
            wr_d    = bus.we_a;
            state_d = ISSUE;
            if (bus.we_a) begin
              we_d   = 1'b1;
              rw_d   = bus.addr_a;
              busw_d = bus.wdata_a;
            end else begin
              ra_d = bus.addr_a;
              rb_d = bus.addr_a;
            end
          end
          pick_b: begin
            gnt_b_d = 1'b1;
            sa_d    = 1'b0;
            sb_d    = 1'b1;
            last_d  = 1'b1;
            wr_d    = bus.we_b;
            state_d = ISSUE;
            if (bus.we_b) begin
              we_d   = 1'b1;
              rw_d   = bus.addr_b;
              busw_d = bus.wdata_b;
            end else begin
              ra_d = bus.addr_b;
              rb_d = bus.addr_b;
            end
          end
          default: ;
        endcase
      end
      ISSUE: state_d = wr_q ? IDLE : RESP;
      RESP: begin
        if (sa_q) begin
          rv_a_d    = 1'b1;
          rdata_a_d = bus.rf_busa;
        end
        if (sb_q) begin
          rv_b_d    = 1'b1;
          rdata_b_d = sa_q ? bus.rf_busb
                           : bus.rf_busa;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      wr_q      <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      rv_a_q    <= 1'b0;
      rv_b_q    <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      busw_q    <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rw_q      <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      wr_q      <= wr_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      rv_a_q    <= rv_a_d;
      rv_b_q    <= rv_b_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      busw_q    <= busw_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rw_q      <= rw_d;
    end
  end

  assign bus.gnt_a           = gnt_a_q;
  assign bus.gnt_b           = gnt_b_q;
  assign bus.rvalid_a        = rv_a_q;
  assign bus.rvalid_b        = rv_b_q;
  assign bus.rdata_a         = rdata_a_q;
  assign bus.rdata_b         = rdata_b_q;
  assign bus.busy            = busy_q;
  assign bus.rf_write_enable = we_q;
  assign bus.rf_ra           = ra_q;
  assign bus.rf_rb           = rb_q;
  assign bus.rf_rw           = rw_q;
  assign bus.rf_busw         = busw_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: timeline model checked every cycle
// plus directed scenarios with literal expectations.
module tb_regfile_arbiter;

`ifdef REGFILE_ARB_DUAL_READ_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  regfile_arbiter #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // register file: write on edge, registered read ports
  logic [3:0] rf_mem [16];
  always @(posedge clk) begin
    if (bus.rf_write_enable) rf_mem[bus.rf_rw] <= bus.rf_busw;
    bus.rf_busa <= rf_mem[bus.rf_ra];
    bus.rf_busb <= rf_mem[bus.rf_rb];
  end

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endfunction

  // ---------------- timeline model ----------------
  logic [3:0] ref_mem [16] = '{default: 4'h0};
  int   k = 0, nf = 0, rva_at = -1, rvb_at = -1;
  bit   last = 1'b1, armed = 1'b0;
  logic [3:0] rva_val, rvb_val;
  logic e_gnt_a, e_gnt_b, e_rv_a, e_rv_b, e_busy, e_we;
  logic [3:0] e_rd_a, e_rd_b, e_ra, e_rb, e_rw, e_busw;
  logic s_rst, s_req_a, s_req_b, s_we_a, s_we_b;
  logic [3:0] s_addr_a, s_addr_b, s_wd_a, s_wd_b;
  int we_cnt = 0, ga_cnt = 0, rva_cnt = 0;

  task automatic model_step();
    bit both_rd, win_b, w;
    logic [3:0] ad, wd;
    e_gnt_a = 0; e_gnt_b = 0; e_rv_a = 0; e_rv_b = 0; e_we = 0;
    if (s_rst) begin
      nf = k + 1; last = 1'b1; rva_at = -1; rvb_at = -1;
      e_rd_a = 0; e_rd_b = 0; e_ra = 0; e_rb = 0;
      e_rw = 0; e_busw = 0; armed = 1'b1;
    end else begin
      if (k == rva_at) begin e_rv_a = 1; e_rd_a = rva_val; end
      if (k == rvb_at) begin e_rv_b = 1; e_rd_b = rvb_val; end
      if (k >= nf && (s_req_a || s_req_b)) begin
        both_rd = DUAL && s_req_a && s_req_b && !s_we_a && !s_we_b;
        if (both_rd) begin
          e_gnt_a = 1; e_gnt_b = 1;
          e_ra = s_addr_a; e_rb = s_addr_b;
          rva_at = k + 2; rva_val = ref_mem[s_addr_a];
          rvb_at = k + 2; rvb_val = ref_mem[s_addr_b];
          nf = k + 3;
        end else begin
          win_b = s_req_b && (!s_req_a || !last);
          last  = win_b;
          w  = win_b ? s_we_b : s_we_a;
          ad = win_b ? s_addr_b : s_addr_a;
          wd = win_b ? s_wd_b : s_wd_a;
          if (win_b) e_gnt_b = 1; else e_gnt_a = 1;
          if (w) begin
            ref_mem[ad] = wd;
            e_we = 1; e_rw = ad; e_busw = wd;
            nf = k + 2;
          end else begin
            e_ra = ad; e_rb = ad;
            if (win_b) begin rvb_at = k + 2; rvb_val = ref_mem[ad]; end
            else begin rva_at = k + 2; rva_val = ref_mem[ad]; end
            nf = k + 3;
          end
        end
      end
    end
    e_busy = (k + 1 < nf);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_req_a = bus.req_a; s_req_b = bus.req_b;
      s_we_a = bus.we_a; s_we_b = bus.we_b;
      s_addr_a = bus.addr_a; s_addr_b = bus.addr_b;
      s_wd_a = bus.wdata_a; s_wd_b = bus.wdata_b;
      k++;
      @(negedge clk);
      model_step();
      if (armed) begin
        chk("gnt_a", bus.gnt_a, e_gnt_a);
        chk("gnt_b", bus.gnt_b, e_gnt_b);
        chk("rvalid_a", bus.rvalid_a, e_rv_a);
        chk("rvalid_b", bus.rvalid_b, e_rv_b);
        chk("rdata_a", bus.rdata_a, e_rd_a);
        chk("rdata_b", bus.rdata_b, e_rd_b);
        chk("busy", bus.busy, e_busy);
        chk("rf_we", bus.rf_write_enable, e_we);
        chk("rf_ra", bus.rf_ra, e_ra);
        chk("rf_rb", bus.rf_rb, e_rb);
        chk("rf_rw", bus.rf_rw, e_rw);
        chk("rf_busw", bus.rf_busw, e_busw);
        if (bus.rf_write_enable === 1'b1) we_cnt++;
        if (bus.gnt_a === 1'b1) ga_cnt++;
        if (bus.rvalid_a === 1'b1) rva_cnt++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_req(input bit b, input bit we,
                        input logic [3:0] addr, input logic [3:0] wd,
                        output time tg, output logic [3:0] rd,
                        output int lat);
    tg = 0; rd = 4'h0; lat = -1;
    if (b) begin
      bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd; bus.req_b = 1;
    end else begin
      bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd; bus.req_a = 1;
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      if ((b ? bus.gnt_b : bus.gnt_a) === 1'b1) begin
        tg = $time; break;
      end
    end
    if (b) bus.req_b = 0; else bus.req_a = 0;
    chk(b ? "gnt_b_seen" : "gnt_a_seen", tg != 0, 1);
    if (!we && tg != 0) begin
      for (int i = 1; i <= 6; i++) begin
        @(posedge clk); #2;
        if ((b ? bus.rvalid_b : bus.rvalid_a) === 1'b1) begin
          rd = b ? bus.rdata_b : bus.rdata_a; lat = i; break;
        end
      end
      chk("rvalid_seen", lat > 0, 1);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) @(posedge clk);
    #2 rst = 0;
  endtask

  time ta, tb_t, ta2, tb2, t0;
  logic [3:0] rda, rdb;
  int la, lb, we0, ga0, rv0;

  initial begin
    bus.req_a = 0; bus.req_b = 0; bus.we_a = 0; bus.we_b = 0;
    bus.addr_a = 0; bus.addr_b = 0; bus.wdata_a = 0; bus.wdata_b = 0;
    #2;
    do_reset(2);
    repeat (4) @(posedge clk);
    #2;
    chk("idle_busy", bus.busy, 0);
    chk("idle_rdata_a", bus.rdata_a, 0);
    chk("idle_we_cnt", we_cnt, 0);

    // write then read on A
    we0 = we_cnt; ga0 = ga_cnt;
    do_req(0, 1, 4'd4, 4'b1010, ta, rda, la);
    do_req(0, 0, 4'd4, 4'h0, ta, rda, la);
    chk("wr_rd_a_data", rda, 4'b1010);
    chk("wr_rd_a_lat", la, 2);
    chk("wr_rd_a_we_pulses", we_cnt - we0, 1);
    chk("wr_rd_a_gnts", ga_cnt - ga0, 2);

    // write contention from a fresh reset
    do_reset(1);
    fork
      do_req(0, 1, 4'd7, 4'b1111, ta, rda, la);
      do_req(1, 1, 4'd11, 4'b1011, tb_t, rdb, lb);
    join
    chk("wr_cont_gap", tb_t - ta, 20);
    do_req(0, 0, 4'd7, 4'h0, ta, rda, la);
    do_req(1, 0, 4'd11, 4'h0, tb_t, rdb, lb);
    chk("rdback_7", rda, 4'b1111);
    chk("rdback_11", rdb, 4'b1011);

    // simultaneous reads: dual grant or 3-cycle serialization
    fork
      do_req(0, 0, 4'd7, 4'h0, ta, rda, la);
      do_req(1, 0, 4'd11, 4'h0, tb_t, rdb, lb);
    join
    chk("dual_gap", tb_t - ta, DUAL ? 0 : 30);
    chk("dual_rd_a", rda, 4'b1111);
    chk("dual_rd_b", rdb, 4'b1011);

    // round robin on back-to-back reads of 7
    fork
      begin
        do_req(0, 0, 4'd7, 4'h0, ta, rda, la);
        chk("rr_a0", rda, 4'b1111);
        do_req(0, 0, 4'd7, 4'h0, ta2, rda, la);
        chk("rr_a1", rda, 4'b1111);
      end
      begin
        do_req(1, 0, 4'd7, 4'h0, tb_t, rdb, lb);
        chk("rr_b0", rdb, 4'b1111);
        do_req(1, 0, 4'd7, 4'h0, tb2, rdb, lb);
        chk("rr_b1", rdb, 4'b1111);
      end
    join
    chk("rr_ab_gap", tb_t - ta, DUAL ? 0 : 30);
    chk("rr_ba_gap", ta2 - tb_t, 30);
    chk("rr_aa_gap", ta2 - ta, DUAL ? 30 : 60);

    // reset in the cycle after a read grant
    rv0 = rva_cnt;
    bus.we_a = 0; bus.addr_a = 4'd4; bus.req_a = 1;
    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (bus.gnt_a === 1'b1) begin t0 = $time; break; end
    end
    bus.req_a = 0;
    chk("rst_rd_gnt", t0 != 0, 1);
    @(posedge clk); #2;
    do_reset(1);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_no_rvalid", rva_cnt - rv0, 0);
    chk("rst_rdata_a", bus.rdata_a, 0);
    chk("rst_busy", bus.busy, 0);
    t0 = $time;
    do_req(1, 0, 4'd11, 4'h0, tb_t, rdb, lb);
    chk("post_rst_b_gap", tb_t - t0, 10);
    chk("post_rst_b_data", rdb, 4'b1011);

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-port round-robin arbiter that shares the 16x4 register file between two requesters (A = 0, B = 1). Each requester issues single read or write transactions through a req/gnt handshake. The arbiter drives the register file's write_enable/ra/rb/rw/busw inputs and returns busa/busb as per-requester read data with a valid pulse. It sits directly in front of the register file; no requester touches the file directly.

## Interface
- ADDR_W, 4, register address width (file depth 2^ADDR_W)
- DATA_W, 4, register data width
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous active-high reset
- req_a / req_b  in  1  transaction request, held until gnt
- we_a / we_b  in  1  1 = write, 0 = read; stable while req high
- addr_a / addr_b  in  ADDR_W  register address; stable while req high
- wdata_a / wdata_b  in  DATA_W  write data; stable while req high
- gnt_a / gnt_b  out  1  one-cycle pulse: request accepted
- rvalid_a / rvalid_b  out  1  one-cycle pulse: rdata valid
- rdata_a / rdata_b  out  DATA_W  read data, held until next rvalid on that port
- busy  out  1  high in any state other than IDLE
- rf_write_enable  out  1  to register file write_enable
- rf_ra, rf_rb, rf_rw  out  ADDR_W  to register file ra, rb, rw
- rf_busw  out  DATA_W  to register file busw
- rf_busa, rf_busb  in  DATA_W  from register file busa, busb

## Operation
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise pick a winner. If only one requester is asserting req, it wins. If both are, the requester other than last_winner wins.
  - Latch the winner's fields into rf_* (write: rf_write_enable=1, rf_rw=addr, rf_busw=wdata; read: rf_write_enable=0, rf_ra=addr).
  - Pulse the winner's gnt, update last_winner, go to ISSUE.
- ISSUE:
  - The register file acts on this edge. All reqs are ignored.
  - Write: clear rf_write_enable, go to IDLE.
  - Read: hold rf_ra/rf_rb, go to RESP.
- RESP:
  - Capture rf_busa (or rf_busb, see Configuration) into the winner's rdata.
  - Pulse its rvalid, go to IDLE.
- rf_write_enable is high only in ISSUE-cycle writes. Otherwise it stays 0, so the file keeps sampling ra/rb.
- rf_rb mirrors rf_ra unless dual read is active.
- last_winner resets to B, so A wins the first contention.

## Timing
- Reset values:
  - gnt_*=0, rvalid_*=0, rdata_*=0, busy=0, rf_write_enable=0, rf_ra=rf_rb=rf_rw=0, rf_busw=0.
  - State=IDLE, last_winner=B.
- Write: req sampled at edge E0, gnt during E0->E1, file written at E1. Next arbitration at E2. Throughput is 1 write per 2 cycles.
- Read: req at E0, gnt during E0->E1, file captures busa at E1, arbiter captures at E2. rvalid/rdata are valid during E2->E3. Latency is 2 cycles from gnt to rvalid; throughput is 1 read per 3 cycles.
- Requester must drop or change req in the cycle gnt is seen. The arbiter does not re-sample req until returning to IDLE.
- Write then read of the same address returns the new data. The write completes at E1; the read is issued no earlier than E2.
- Loser of a contention keeps req high and is served in the next IDLE, so no starvation.
- rst mid-transaction:
  - Aborts the transaction. No rvalid is produced, and a granted read is lost.
  - All outputs and last_winner return to reset values at that edge.
  - A write already sampled by the file is not undone.
- Address wrap is not applicable. Any ADDR_W value is legal and passed through unchanged.

## Configuration
- REGFILE_ARB_DUAL_READ_EN defined:
  - When both reqs are reads in the same IDLE cycle, both are granted together (gnt_a and gnt_b pulse together).
  - rf_ra=addr_a, rf_rb=addr_b. In RESP, rdata_a<=rf_busa and rdata_b<=rf_busb, with both rvalid pulses together.
  - last_winner is unchanged.
- Undefined: reads are serialized by round robin like writes, and rf_rb always mirrors rf_ra.

## Test plan
- Reset then idle: rst=1 for 2 cycles, no reqs -> all outputs 0, busy=0, rf_write_enable never 1.
- Write then read on A: write addr 4 data 4'b1010, then read addr 4 -> gnt_a pulses twice, rf_write_enable=1 for exactly one cycle, rvalid_a 2 cycles after second gnt with rdata_a=4'b1010.
- Contention on writes: A writes 7<=4'b1111 and B writes 11<=4'b1011 in the same cycle -> gnt_a first, gnt_b 2 cycles later; reading back 7 and 11 gives 4'b1111 and 4'b1011.
- Round-robin fairness: A and B issue back-to-back reads of address 7 with both reqs always high -> grants alternate A,B,A,B and each rvalid carries 4'b1111.
- Dual read (macro defined): A reads 7 and B reads 11 in the same cycle -> gnt_a and gnt_b pulse together, rvalid_a/rvalid_b together with 4'b1111/4'b1011. Without the macro, the same stimulus gives serialized grants 3 cycles apart.
- Reset mid-read: rst asserted in the cycle after gnt_a for a read -> no rvalid_a, rdata_a=0, state IDLE. A fresh req_b is then granted first, since last_winner=B rule does not apply to a single requester.
